// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: stall/bubble/flush/redirect and data-memory handshake.
// Optional stall-cycle counter enabled by defining PIPE_CTRL_STALL_CNT_EN.

`ifndef MEM_RW
`define MEM_RW 2
`endif
`ifndef MEM_DISABLE
`define MEM_DISABLE 2'b00
`endif
`ifndef MEM_READ
`define MEM_READ 2'b01
`endif
`ifndef MEM_WRITE
`define MEM_WRITE 2'b10
`endif

module pipe_ctrl #(
    parameter int unsigned FENCE_DRAIN_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        id_rs1_raddr,
    input  logic [4:0]        id_rs2_raddr,
    input  logic              id_fence,
    input  logic [`MEM_RW-1:0] ex_mem_rw,
    input  logic [4:0]        ex_rd_waddr,
    input  logic              ex_br_taken,
    input  logic [31:0]       ex_br_target,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    output logic              dmem_req,
    output logic              if_stall,
    output logic              id_stall,
    output logic              ex_stall,
    output logic              ex_bubble,
    output logic              id_flush,
    output logic              pc_redirect,
    output logic [31:0]       pc_target,
    output logic [31:0]       stall_cnt
);

    localparam int unsigned CNT_W = (FENCE_DRAIN_CYCLES > 1) ? $clog2(FENCE_DRAIN_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_REQ  = 2'd1,
        S_MEM_RESP = 2'd2,
        S_FENCE    = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               mem_op, is_load, is_store, load_use, done, resolve;

    assign mem_op   = (ex_mem_rw != `MEM_DISABLE);
    assign is_load  = (ex_mem_rw == `MEM_READ);
    assign is_store = (ex_mem_rw == `MEM_WRITE);
    assign done     = dmem_gnt & (is_store | dmem_rvalid);
    assign load_use = is_load && (ex_rd_waddr != 5'd0) &&
                      ((ex_rd_waddr == id_rs1_raddr) || (ex_rd_waddr == id_rs2_raddr));

    // State and fence drain counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state and hazard outputs
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        resolve     = 1'b0;
        dmem_req    = 1'b0;
        if_stall    = 1'b0;
        id_stall    = 1'b0;
        ex_stall    = 1'b0;
        ex_bubble   = 1'b0;
        id_flush    = 1'b0;
        pc_redirect = 1'b0;
        pc_target   = 32'd0;

        unique case (state)
            S_RUN: begin
                if (mem_op) begin
                    dmem_req = 1'b1;
                    if (done) begin
                        resolve = 1'b1;
                    end else begin
                        {if_stall, id_stall, ex_stall} = 3'b111;
                        state_nxt = dmem_gnt ? S_MEM_RESP : S_MEM_REQ;
                    end
                end else if (ex_br_taken) begin
                    pc_redirect = 1'b1;
                    pc_target   = ex_br_target;
                    id_flush    = 1'b1;
                    ex_bubble   = 1'b1;
                end else begin
                    resolve = 1'b1;
                end
            end
            S_MEM_REQ: begin
                dmem_req = 1'b1;
                if (done) begin
                    resolve   = 1'b1;
                    state_nxt = S_RUN;
                end else begin
                    {if_stall, id_stall, ex_stall} = 3'b111;
                    if (dmem_gnt) state_nxt = S_MEM_RESP;
                end
            end
            S_MEM_RESP: begin
                if (dmem_rvalid) begin
                    resolve   = 1'b1;
                    state_nxt = S_RUN;
                end else begin
                    {if_stall, id_stall, ex_stall} = 3'b111;
                end
            end
            S_FENCE: begin
                if (cnt == '0) begin
                    state_nxt = S_RUN;
                end else begin
                    {if_stall, id_stall, ex_bubble} = 3'b111;
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: state_nxt = S_RUN;
        endcase

        // Once execute is free to advance: load-use bubble beats fence entry
        if (resolve) begin
            if (load_use) begin
                {if_stall, id_stall, ex_bubble} = 3'b111;
            end else if (id_fence) begin
                {if_stall, id_stall, ex_bubble} = 3'b111;
                state_nxt = S_FENCE;
                cnt_nxt   = CNT_W'(FENCE_DRAIN_CYCLES - 1);
            end
        end

        if (rst) begin
            dmem_req    = 1'b0;
            if_stall    = 1'b0;
            id_stall    = 1'b0;
            ex_stall    = 1'b0;
            ex_bubble   = 1'b0;
            id_flush    = 1'b0;
            pc_redirect = 1'b0;
            pc_target   = 32'd0;
        end
    end

`ifdef PIPE_CTRL_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    // Free-running stall-cycle counter, wraps naturally
    always_ff @(posedge clk) begin
        if (rst)           stall_cnt_q <= 32'd0;
        else if (if_stall) stall_cnt_q <= stall_cnt_q + 32'd1;
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: memory handshake, load-use, branch, fence and reset cases.

`ifndef MEM_RW
`define MEM_RW 2
`endif
`ifndef MEM_DISABLE
`define MEM_DISABLE 2'b00
`endif
`ifndef MEM_READ
`define MEM_READ 2'b01
`endif
`ifndef MEM_WRITE
`define MEM_WRITE 2'b10
`endif

module tb_pipe_ctrl;

    localparam int unsigned DRAIN = 3;
`ifdef PIPE_CTRL_STALL_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic [4:0]         id_rs1_raddr, id_rs2_raddr, ex_rd_waddr;
    logic               id_fence, ex_br_taken, dmem_gnt, dmem_rvalid;
    logic [`MEM_RW-1:0] ex_mem_rw;
    logic [31:0]        ex_br_target;
    logic               dmem_req, if_stall, id_stall, ex_stall, ex_bubble, id_flush, pc_redirect;
    logic [31:0]        pc_target, stall_cnt;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    pipe_ctrl #(.FENCE_DRAIN_CYCLES(DRAIN)) dut (
        .clk(clk), .rst(rst),
        .id_rs1_raddr(id_rs1_raddr), .id_rs2_raddr(id_rs2_raddr), .id_fence(id_fence),
        .ex_mem_rw(ex_mem_rw), .ex_rd_waddr(ex_rd_waddr),
        .ex_br_taken(ex_br_taken), .ex_br_target(ex_br_target),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
        .dmem_req(dmem_req), .if_stall(if_stall), .id_stall(id_stall), .ex_stall(ex_stall),
        .ex_bubble(ex_bubble), .id_flush(id_flush), .pc_redirect(pc_redirect),
        .pc_target(pc_target), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Control vector order: {dmem_req, if_stall, id_stall, ex_stall, ex_bubble, id_flush, pc_redirect}
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        id_rs1_raddr = 5'd1;
        id_rs2_raddr = 5'd2;
        ex_rd_waddr  = 5'd0;
        id_fence     = 1'b0;
        ex_mem_rw    = `MEM_DISABLE;
        ex_br_taken  = 1'b0;
        ex_br_target = 32'd0;
        dmem_gnt     = 1'b0;
        dmem_rvalid  = 1'b0;
    endtask

    // Sample the combinational outputs mid-cycle, then move past the next rising edge
    task automatic cyc(input string tag, input logic [6:0] exp_ctl);
        @(negedge clk);
        check(tag, 32'({dmem_req, if_stall, id_stall, ex_stall, ex_bubble, id_flush, pc_redirect}),
              32'(exp_ctl));
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_cnt(input int unsigned n);
        return CNT_EN ? 32'(n) : 32'd0;
    endfunction

    initial begin
        idle();
        rst       = 1'b1;
        ex_mem_rw = `MEM_READ;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_pc_target", pc_target, 32'd0);
        check("rst_stall_cnt", stall_cnt, 32'd0);
        cyc("rst_ctl_forced_zero", 7'b0000000);
        rst = 1'b0;
        idle();
        cyc("idle_after_rst", 7'b0000000);

        // single-cycle load
        ex_mem_rw = `MEM_READ; ex_rd_waddr = 5'd7; dmem_gnt = 1'b1; dmem_rvalid = 1'b1;
        cyc("load_fast", 7'b1000000);
        idle();
        cyc("load_fast_next_run", 7'b0000000);

        // slow load: gnt after 2 cycles, rvalid 3 cycles after gnt
        ex_mem_rw = `MEM_READ; ex_rd_waddr = 5'd9;
        cyc("slow_c0_req", 7'b1111000);
        cyc("slow_c1_req", 7'b1111000);
        dmem_gnt = 1'b1;
        cyc("slow_c2_gnt", 7'b1111000);
        dmem_gnt = 1'b0;
        cyc("slow_c3_resp", 7'b0111000);
        cyc("slow_c4_resp", 7'b0111000);
        dmem_rvalid = 1'b1;
        cyc("slow_c5_rvalid", 7'b0000000);
        idle();
        @(negedge clk);
        check("slow_stall_cnt", stall_cnt, exp_cnt(5));
        cyc("slow_after_run", 7'b0000000);

        // load-use on rs2
        ex_mem_rw = `MEM_READ; ex_rd_waddr = 5'd5; id_rs2_raddr = 5'd5;
        dmem_gnt = 1'b1; dmem_rvalid = 1'b1;
        cyc("load_use_bubble", 7'b1110100);
        idle();
        cyc("load_use_once", 7'b0000000);
        ex_mem_rw = `MEM_READ; ex_rd_waddr = 5'd0; id_rs1_raddr = 5'd0;
        dmem_gnt = 1'b1; dmem_rvalid = 1'b1;
        cyc("load_x0_no_bubble", 7'b1000000);
        idle();
        @(negedge clk);
        check("load_use_stall_cnt", stall_cnt, exp_cnt(6));

        // taken branch
        ex_br_taken = 1'b1; ex_br_target = 32'h0000_0100;
        @(negedge clk);
        check("br_target", pc_target, 32'h0000_0100);
        cyc("br_redirect", 7'b0000111);
        idle();
        @(negedge clk);
        check("br_target_cleared", pc_target, 32'd0);
        cyc("br_once", 7'b0000000);
        ex_br_taken = 1'b1; ex_br_target = 32'h0000_0100;
        ex_mem_rw = `MEM_WRITE; dmem_gnt = 1'b1;
        @(negedge clk);
        check("br_store_target", pc_target, 32'd0);
        cyc("br_with_store", 7'b1000000);
        idle();

        // fence drain of DRAIN cycles
        id_fence = 1'b1;
        cyc("fence_enter", 7'b0110100);
        cyc("fence_drain1", 7'b0110100);
        cyc("fence_drain2", 7'b0110100);
        cyc("fence_release", 7'b0000000);
        idle();
        cyc("fence_run", 7'b0000000);
        @(negedge clk);
        check("fence_stall_cnt", stall_cnt, exp_cnt(9));

        // fence with redirect is flushed
        id_fence = 1'b1; ex_br_taken = 1'b1; ex_br_target = 32'h0000_0200;
        cyc("fence_br_redirect", 7'b0000111);
        idle();
        cyc("fence_br_no_fence", 7'b0000000);

        // reset in MEM_RESP
        ex_mem_rw = `MEM_READ; ex_rd_waddr = 5'd3; dmem_gnt = 1'b1;
        cyc("rstmid_gnt", 7'b1111000);
        dmem_gnt = 1'b0;
        cyc("rstmid_resp", 7'b0111000);
        rst = 1'b1;
        cyc("rstmid_forced", 7'b0000000);
        rst = 1'b0;
        idle();
        dmem_rvalid = 1'b1;
        @(negedge clk);
        check("rstmid_stall_cnt", stall_cnt, 32'd0);
        cyc("rstmid_late_rvalid", 7'b0000000);
        ex_mem_rw = `MEM_READ; ex_rd_waddr = 5'd3; dmem_rvalid = 1'b0;
        cyc("rstmid_back_in_run", 7'b1111000);
        idle();
        dmem_rvalid = 1'b1;
        ex_mem_rw = `MEM_READ; ex_rd_waddr = 5'd3; dmem_gnt = 1'b1;
        cyc("rstmid_finish_load", 7'b1000000);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the RV32I core. Sits beside the decode and execute stages and produces the stall, bubble, flush and PC-redirect controls that move instructions from fetch through decode to execute. It also owns the data-memory request handshake for loads and stores. Its hazard sources are:
- load-use dependencies;
- taken branches and jumps resolved in execute;
- multi-cycle memory accesses;
- FENCE/FENCE.I drain.

## Interface
Parameters:
- FENCE_DRAIN_CYCLES, 2, number of cycles fetch/decode is held after a FENCE/FENCE.I reaches decode (≥1)

Ports:
- clk  input  1  core clock
- rst  input  1  reset; synchronous, active-high
- id_rs1_raddr  input  5  rs1 read address of the instruction in decode
- id_rs2_raddr  input  5  rs2 read address of the instruction in decode
- id_fence  input  1  instruction in decode is FENCE or FENCE.I
- ex_mem_rw  input  `MEM_RW  memory op of the instruction in execute (`MEM_READ / `MEM_WRITE / `MEM_DISABLE)
- ex_rd_waddr  input  5  destination register of the instruction in execute
- ex_br_taken  input  1  branch/jump in execute is taken
- ex_br_target  input  32  redirect target
- dmem_gnt  input  1  memory accepted the request
- dmem_rvalid  input  1  load data valid
- dmem_req  output  1  memory request
- if_stall  output  1  hold PC and fetch register
- id_stall  output  1  hold decode register
- ex_stall  output  1  hold execute register
- ex_bubble  output  1  load NOP into execute register
- id_flush  output  1  load NOP into decode register
- pc_redirect  output  1  PC loads pc_target
- pc_target  output  32  redirect address
- stall_cnt  output  32  stall-cycle counter

## Operation
States: RUN, MEM_REQ, MEM_RESP, FENCE.

Definitions:
- mem_op = ex_mem_rw != `MEM_DISABLE.
- done (valid in RUN and MEM_REQ) = dmem_gnt & (store | dmem_rvalid). In MEM_RESP, done = dmem_rvalid.

Memory access:
- dmem_req = mem_op in RUN, and constant 1 in MEM_REQ. It is 0 in MEM_RESP and FENCE.
- RUN with mem_op:
  - done → stay in RUN (single-cycle access);
  - no gnt → MEM_REQ;
  - gnt on a load without rvalid → MEM_RESP.
- MEM_REQ: gnt & rvalid, or gnt on a store → RUN; gnt on a load without rvalid → MEM_RESP.
- MEM_RESP: rvalid → RUN.
- While the access is pending and not done: if_stall = id_stall = ex_stall = 1.
- In the done cycle all stalls are 0, so execute advances on that edge.

Branch:
- RUN, no mem_op, ex_br_taken → pc_redirect = 1, pc_target = ex_br_target, id_flush = 1, ex_bubble = 1.
- Otherwise pc_target = 0.

Load-use:
- Triggers in RUN when ex_mem_rw == `MEM_READ, ex_rd_waddr != 0, and ex_rd_waddr matches id_rs1_raddr or id_rs2_raddr.
- Response: if_stall = id_stall = 1, ex_bubble = 1 for one cycle.
- This bubble applies in the cycle the load completes.
- While the load is pending, the memory stall governs.

Fence:
- RUN, id_fence, no other hazard → enter FENCE with counter = FENCE_DRAIN_CYCLES−1.
- In the entry cycle and in every FENCE cycle: if_stall = id_stall = 1, ex_bubble = 1.
- The counter decrements each FENCE cycle. In the cycle it reads 0, stalls deassert and the state returns to RUN.

Priority, high to low:
1. pending memory access
2. branch redirect
3. load-use
4. fence

Simultaneous hazards resolve as follows:
- A taken branch alongside mem_op is ignored.
- A fence coinciding with a redirect is flushed, so FENCE is not entered.

## Timing
- All hazard outputs are combinational from state and inputs. State, counter and stall_cnt are registered on clk rising.
- Reset: state = RUN, counter = 0, stall_cnt = 0. While rst = 1 every output is forced to 0, including dmem_req.
- Reset during MEM_REQ/MEM_RESP abandons the access and returns to RUN. A late dmem_rvalid in RUN without mem_op is ignored.
- Single-cycle memory (gnt and rvalid in the request cycle) costs 0 stall cycles.
- Each gnt-less cycle adds 1 stall cycle.
- A load-use dependency costs exactly 1 bubble.
- A fence costs FENCE_DRAIN_CYCLES stall cycles.
- A taken branch costs 2 flushed slots with no stall.

## Configuration
- PIPE_CTRL_STALL_CNT_EN defined: stall_cnt increments every cycle with if_stall = 1 and wraps from 0xFFFFFFFF to 0.
- Undefined: stall_cnt is tied to 0 and no counter register exists.

## Test plan
- Load completes immediately: ex_mem_rw = `MEM_READ, gnt = rvalid = 1 in the same cycle → dmem_req = 1 for 1 cycle, all stalls 0, state stays RUN.
- Slow load: gnt after 2 cycles, rvalid 3 cycles after gnt → stalls high for 5 cycles, states MEM_REQ → MEM_RESP → RUN, stall_cnt = 5 (macro on).
- Load-use: load x5 in execute, decode reads x5 as rs2, single-cycle memory → exactly one ex_bubble with if/id stalled. The same case with rd = x0 → no bubble.
- Taken branch: ex_br_taken = 1, ex_br_target = 0x00000100 → pc_redirect = 1, pc_target = 0x100, id_flush = ex_bubble = 1 for one cycle. With a store in execute at the same time → no redirect.
- Fence with FENCE_DRAIN_CYCLES = 3 → if_stall high exactly 3 cycles, then RUN.
- rst asserted mid MEM_RESP → next cycle state RUN, dmem_req = 0, stall_cnt = 0.
